adc_spi_arbiter: RTL and testbench
==================================

# adc_spi_arbiter

Shares one 3-wire SPI shift engine among the four channel converters (ch1–ch4). Each converter's configuration registers are written or read back through its own chip-select, SCLK and bidirectional SDIN pin. The block sits in the core clock domain between the control-register logic, which raises per-channel requests, and the chip-level SDIN tristate pins, which use the `_i/_o/_t` convention. It runs round-robin arbitration, serializes 16-bit frames, handles SDIN turnaround on reads, and returns a one-cycle acknowledge carrying the read data.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per SCLK half-period; legal range 2..255.
- `clk` in 1: core clock; all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in 4: per-channel request; bit n is ch(n+1); level-held until `ack[n]`.
- `req_rw` in 4: 1 = read, 0 = write; sampled at grant.
- `req_addr` in 28: 7-bit register address per channel; channel n uses `[7n+6:7n]`.
- `req_wdata` in 32: 8-bit write data per channel; channel n uses `[8n+7:8n]`.
- `ack` out 4: one-cycle completion pulse for the granted channel.
- `rdata` out 8: read data; valid only in the cycle `ack` is high.
- `busy` out 1: high from grant until the end of the gap.
- `spi_cs` out 4: chip-selects, active-low, idle `4'hF`.
- `spi_sclk` out 4: SCLK per channel, idle low; toggles only on the granted channel.
- `sdin_i` in 4: SDIN pin input.
- `sdin_o` out 4: SDIN drive value.
- `sdin_t` out 4: SDIN drive enable; 1 = drive, 0 = high-Z.

## Operation
- Reset values:
  - `spi_cs` = `4'hF`, `spi_sclk` = 0, `sdin_o` = 0, `sdin_t` = 0.
  - `ack` = 0, `rdata` = 0, `busy` = 0.
  - Round-robin pointer "last granted" = 3, so ch1 has priority after reset.
- Frame: 16 bits, MSB first. Bit 15 = R/W (1 = read), bits 14:8 = address, bits 7:0 = data.
- States:
  - IDLE → SETUP when any `req` is high. Grant goes to the first requesting channel after "last granted", searching upward modulo 4. At grant the block latches the channel index, rw, address and wdata, then updates the pointer.
  - SETUP, `CLK_DIV` cycles: `cs` low, SCLK low, `sdin_t` = 1, `sdin_o` = bit 15.
  - SHIFT, 16 bits of 2×`CLK_DIV` cycles each: SCLK low half, then high half. `sdin_o` changes only at the start of a low half. The block samples `sdin_i` on the last cycle of each high half.
  - HOLD, `CLK_DIV` cycles: SCLK low, `cs` still low.
  - DONE, 1 cycle: `cs` high, `sdin_t` = 0, `ack[n]` = 1, `rdata` presented.
  - GAP, `CLK_DIV` − 1 cycles: then return to IDLE.
- Read turnaround: `sdin_t` falls to 0 at the start of the low half of bit 7, so the first data bit has a full low half to settle. Bits 7:0 sampled from `sdin_i[n]` form `rdata`, MSB first.
- Write: `rdata` = `8'h00` at ack.
- Request handling:
  - Deasserting `req[n]` after grant does not abort the frame; `ack[n]` still pulses.
  - `req[n]` still high in the cycle after `ack[n]` counts as a new request. It competes fairly, so other pending channels are served first.
  - Request changes during a frame affect only the next arbitration.
- Non-granted channels hold `cs` high, SCLK low and `sdin_t` = 0 throughout.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronously). The frame is lost and no ack is issued.

## Timing
- Let E be the edge at which IDLE sees a request. `cs` goes low at edge E and stays low for exactly 34×`CLK_DIV` cycles.
- `ack` is high for the cycle starting at edge E + 34×`CLK_DIV`.
- The earliest next `cs` fall is at edge E + 35×`CLK_DIV`.
- With `CLK_DIV` = 4: `cs` low for 136 cycles, ack at E + 136, next grant at E + 140.
- SCLK period is 2×`CLK_DIV` `clk` cycles with 50% duty.

## Configuration
- `ADC_SPI_READBACK_EN` defined: read frames are supported as described above.
- `ADC_SPI_READBACK_EN` undefined:
  - `req_rw` is ignored and bit 15 is always sent as 0.
  - `sdin_t` stays 1 for the whole frame.
  - `sdin_i` is unused and `rdata` is tied to `8'h00`.
  - All timing is unchanged.

## Test plan
- Single write: `CLK_DIV` = 4, `req` = `4'b0001`, addr `7'h14`, wdata `8'hA5`, rw = 0.
  - `spi_cs[0]` low for 136 cycles; 16 SCLK rising edges capture `16'h14A5`.
  - `ack` = `4'b0001` at E + 136; `rdata` = `8'h00`.
- Read: ch3, addr `7'h01`, rw = 1; the bench drives `8'h3C` on `sdin_i[2]` after turnaround.
  - Captured header `8'h81`.
  - `sdin_t[2]` falls at the start of bit 7's low half.
  - `rdata` = `8'h3C` with `ack[2]`.
- Fairness: `req` = `4'b1111` held continuously.
  - Grant order is ch1, ch2, ch3, ch4, ch1.
  - Consecutive `cs` falls are 140 cycles apart.
- Withdrawn request: `req[1]` pulsed for one cycle in IDLE.
  - The full frame still completes and `ack[1]` pulses.
- Reset mid-frame: `reset_n` low at bit 6.
  - All `cs` go high, SCLK low and `sdin_t` = 0 within the same cycle, and no ack is issued.
  - After release, `req` = `4'b1010` grants ch2 first.
- Macro off: a read request on ch1.
  - Frame header bit 15 = 0, `sdin_t[0]` stays 1 through bit 0, and `rdata` = 0.

Source files
------------

// File: rtl/adc_spi_arbiter.sv
// adc_spi_arbiter: round-robin owner of one 3-wire SPI shift engine
// shared by four converter channels.
//
// Optional feature macro: ADC_SPI_READBACK_EN (read frames, SDIN turnaround).
//
// Ports:
//   clk, reset_n        core clock, async active-low reset
//   req/req_rw          per-channel request level and read(1)/write(0)
//   req_addr/req_wdata  packed 7-bit address / 8-bit data per channel
//   ack/rdata           one-cycle completion pulse and read data
//   busy                high from grant until the inter-frame gap ends
//   spi_cs/spi_sclk     per-channel chip-select (active low) and SCLK
//   sdin_i/o/t          per-channel SDIN pin input, drive value, enable
module adc_spi_arbiter #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  req,
    input  logic [3:0]  req_rw,
    input  logic [27:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [3:0]  ack,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic [3:0]  spi_cs,
    output logic [3:0]  spi_sclk,
    input  logic [3:0]  sdin_i,
    output logic [3:0]  sdin_o,
    output logic [3:0]  sdin_t
);

    typedef enum logic [2:0] {
        IDLE, SETUP, SHIFT, HOLD, DONE, GAP
    } state_t;

    localparam logic [7:0] DM1 = 8'(CLK_DIV - 1);
    localparam logic [7:0] DM2 = 8'(CLK_DIV - 2);

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic        hi, hi_n;
    logic [3:0]  bitc, bitc_n;
    logic [15:0] shreg, shreg_n;
    logic [1:0]  ch, ch_n;
    logic [1:0]  last, last_n;
    logic        gnt_any;
    logic [1:0]  gnt_idx;
    logic [1:0]  cand;
    logic        do_load;
    logic        hdr_rw;
    logic        cnt_last;
    logic        frame;
    logic        drive;

`ifdef ADC_SPI_READBACK_EN
    logic        rw, rw_n;
    logic [7:0]  rx, rx_n;
`else
    logic        unused_in;
    assign unused_in = ^{req_rw, sdin_i};
`endif

    // Later k overwrites earlier, so the nearest channel after
    // `last` wins; k = 4 wraps onto `last` itself (lowest priority).
    always_comb begin
        gnt_any = |req;
        gnt_idx = last;
        cand    = last;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (req[cand]) gnt_idx = cand;
        end
    end

`ifdef ADC_SPI_READBACK_EN
    assign hdr_rw = req_rw[gnt_idx];
`else
    assign hdr_rw = 1'b0;
`endif

    assign cnt_last = (cnt == DM1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= 1'b0;
            bitc  <= '0;
            shreg <= '0;
            ch    <= '0;
            last  <= 2'd3;
`ifdef ADC_SPI_READBACK_EN
            rw    <= 1'b0;
            rx    <= '0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            hi    <= hi_n;
            bitc  <= bitc_n;
            shreg <= shreg_n;
            ch    <= ch_n;
            last  <= last_n;
`ifdef ADC_SPI_READBACK_EN
            rw    <= rw_n;
            rx    <= rx_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hi_n    = hi;
        bitc_n  = bitc;
        shreg_n = shreg;
        ch_n    = ch;
        last_n  = last;
        do_load = 1'b0;
`ifdef ADC_SPI_READBACK_EN
        rw_n    = rw;
        rx_n    = rx;
`endif
        unique case (state)
            IDLE: do_load = gnt_any;
            SETUP: begin
                cnt_n = cnt + 8'd1;
                if (cnt_last) begin
                    state_n = SHIFT;
                    cnt_n   = '0;
                    hi_n    = 1'b0;
                    bitc_n  = '0;
                end
            end
            SHIFT: begin
                cnt_n = cnt + 8'd1;
                if (cnt_last) begin
                    cnt_n = '0;
                    hi_n  = !hi;
                    if (hi) begin
                        // End of high half: sample, then advance
                        // so the next bit appears with the low half.
                        shreg_n = {shreg[14:0], 1'b0};
                        bitc_n  = bitc + 4'd1;
`ifdef ADC_SPI_READBACK_EN
                        rx_n = {rx[6:0], sdin_i[ch]};
`endif
                        if (bitc == 4'd15) state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                cnt_n = cnt + 8'd1;
                if (cnt_last) begin
                    state_n = DONE;
                    cnt_n   = '0;
                end
            end
            DONE: begin
                state_n = GAP;
                cnt_n   = '0;
            end
            GAP: begin
                cnt_n = cnt + 8'd1;
                // Last gap cycle arbitrates directly so back-to-back
                // frames start exactly 35 divider periods apart.
                if (cnt == DM2) begin
                    state_n = IDLE;
                    do_load = gnt_any;
                end
            end
            default: state_n = IDLE;
        endcase

        if (do_load) begin
            state_n = SETUP;
            cnt_n   = '0;
            ch_n    = gnt_idx;
            last_n  = gnt_idx;
            shreg_n = {hdr_rw,
                       req_addr[int'(gnt_idx) * 7 +: 7],
                       req_wdata[int'(gnt_idx) * 8 +: 8]};
`ifdef ADC_SPI_READBACK_EN
            rw_n    = hdr_rw;
`endif
        end
    end

    assign frame = (state == SETUP) || (state == SHIFT) ||
                   (state == HOLD);

    // Reads release SDIN from the low half of bit 7 onward.
`ifdef ADC_SPI_READBACK_EN
    assign drive = !(rw && ((state == HOLD) ||
                            ((state == SHIFT) && bitc[3])));
`else
    assign drive = 1'b1;
`endif

    assign busy = (state != IDLE);

    always_comb begin
        spi_cs   = 4'hF;
        spi_sclk = 4'h0;
        sdin_o   = 4'h0;
        sdin_t   = 4'h0;
        ack      = 4'h0;
        rdata    = 8'h00;
        if (frame) begin
            spi_cs[ch] = 1'b0;
            sdin_o[ch] = shreg[15] & drive;
            sdin_t[ch] = drive;
        end
        if ((state == SHIFT) && hi) spi_sclk[ch] = 1'b1;
        if (state == DONE) begin
            ack[ch] = 1'b1;
`ifdef ADC_SPI_READBACK_EN
            rdata = rw ? rx : 8'h00;
`endif
        end
    end

endmodule

// File: tb/tb_adc_spi_arbiter.sv
// tb_adc_spi_arbiter: directed bench for adc_spi_arbiter (CLK_DIV = 4).
// Negedge monitor captures frames; main thread acts at negedge + 1.
module tb_adc_spi_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  req_rw = '0;
    logic [27:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  ack;
    logic [7:0]  rdata;
    logic        busy;
    logic [3:0]  spi_cs;
    logic [3:0]  spi_sclk;
    logic [3:0]  sdin_i = '0;
    logic [3:0]  sdin_o;
    logic [3:0]  sdin_t;

    adc_spi_arbiter #(.CLK_DIV(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_rw   (req_rw),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .ack      (ack),
        .rdata    (rdata),
        .busy     (busy),
        .spi_cs   (spi_cs),
        .spi_sclk (spi_sclk),
        .sdin_i   (sdin_i),
        .sdin_o   (sdin_o),
        .sdin_t   (sdin_t)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] cap [4];
    int          rises [4];
    int          tlow [4];
    int          tf_rises [4];
    logic        tf_onfall [4];
    int          rise_cyc [4];
    int          fall_q [$];
    int          order [$];
    int          acks = 0;
    int          ack_cyc = 0;
    logic [3:0]  ack_val = '0;
    logic [7:0]  ack_rd = '0;
    logic [3:0]  prev_cs = 4'hF;
    logic [3:0]  prev_sclk = '0;
    logic [3:0]  prev_t = '0;

    logic        rd_on = 1'b0;
    int          rd_ch = 0;
    logic [7:0]  rd_byte = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (prev_cs[n] && !spi_cs[n]) begin
                fall_q.push_back(cyc);
                order.push_back(n);
                cap[n]      <= '0;
                rises[n]    <= 0;
                tlow[n]     <= 0;
                tf_rises[n] <= -1;
                tf_onfall[n] <= 1'b0;
            end else begin
                if (!spi_cs[n] && !sdin_t[n]) tlow[n] <= tlow[n] + 1;
                if (!prev_sclk[n] && spi_sclk[n]) begin
                    cap[n]   <= {cap[n][14:0], sdin_o[n]};
                    rises[n] <= rises[n] + 1;
                end
                if (!spi_cs[n] && prev_t[n] && !sdin_t[n]) begin
                    tf_rises[n]  <= rises[n];
                    tf_onfall[n] <= prev_sclk[n] && !spi_sclk[n];
                end
            end
            if (!prev_cs[n] && spi_cs[n]) rise_cyc[n] <= cyc;
        end
        if (ack != 4'h0) begin
            acks    <= acks + 1;
            ack_cyc <= cyc;
            ack_val <= ack;
            ack_rd  <= rdata;
        end
        prev_cs   <= spi_cs;
        prev_sclk <= spi_sclk;
        prev_t    <= sdin_t;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present read data bit k during both halves of frame bit k.
    task automatic drive_rd;
        int idx;
        sdin_i = 4'h0;
        if (rd_on && !spi_cs[rd_ch]) begin
            idx = spi_sclk[rd_ch] ? 16 - rises[rd_ch] : 15 - rises[rd_ch];
            if (idx >= 0 && idx <= 7) sdin_i[rd_ch] = rd_byte[idx];
        end
    endtask

    task automatic step;
        @(negedge clk);
        #1;
        drive_rd();
    endtask

    task automatic wait_ack(input int lim);
        int a0;
        int n;
        a0 = acks;
        n = 0;
        while (acks == a0 && n < lim) begin
            step();
            n++;
        end
        if (acks == a0) chk("ack_timeout", 0, 1);
    endtask

    task automatic wait_fall(input int cnt, input int lim);
        int n;
        n = 0;
        while (order.size() < cnt && n < lim) begin
            step();
            n++;
        end
        if (order.size() < cnt) chk("fall_timeout", 0, 1);
    endtask

    function automatic int q_at(input int q [$], input int i);
        return (i < q.size()) ? q[i] : -999;
    endfunction

    initial begin
        int a0;
        int n;
        repeat (3) step();
        reset_n = 1'b1;
        step();

        chk("rst_cs", 32'(spi_cs), 32'hF);
        chk("rst_sclk", 32'(spi_sclk), 0);
        chk("rst_sdo", 32'(sdin_o), 0);
        chk("rst_sdt", 32'(sdin_t), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_busy", 32'(busy), 0);

        req_addr  = {7'h44, 7'h33, 7'h22, 7'h11};
        req_wdata = 32'h44332211;
        order.delete();
        fall_q.delete();
        req = 4'hF;
        wait_fall(5, 800);
        req = 4'h0;
        for (int i = 0; i < 5; i++)
            chk("rr_order", 32'(q_at(order, i)), 32'(i % 4));
        for (int i = 1; i < 5; i++)
            chk("rr_gap", 32'(q_at(fall_q, i) - q_at(fall_q, i - 1)), 140);
        wait_ack(200);
        repeat (8) step();

        req_addr[6:0]  = 7'h14;
        req_wdata[7:0] = 8'hA5;
        fall_q.delete();
        req = 4'b0001;
        wait_ack(200);
        req = 4'h0;
        chk("wr_ack", 32'(ack_val), 32'h1);
        chk("wr_rdata", 32'(ack_rd), 0);
        chk("wr_frame", 32'(cap[0]), 32'h14A5);
        chk("wr_edges", 32'(rises[0]), 16);
        chk("wr_cs_len", 32'(rise_cyc[0] - q_at(fall_q, 0)), 136);
        chk("wr_ack_t", 32'(ack_cyc - q_at(fall_q, 0)), 136);
        chk("wr_sdt", 32'(tlow[0]), 0);
        repeat (8) step();

        fall_q.delete();
        req = 4'b0010;
        step();
        req = 4'h0;
        wait_ack(200);
        chk("wd_ack", 32'(ack_val), 32'h2);
        chk("wd_ack_t", 32'(ack_cyc - q_at(fall_q, 0)), 136);
        chk("wd_frame", 32'(cap[1]), 32'h2222);
        repeat (8) step();

`ifdef ADC_SPI_READBACK_EN
        req_addr[20:14] = 7'h01;
        req_rw  = 4'b0100;
        rd_on   = 1'b1;
        rd_ch   = 2;
        rd_byte = 8'h3C;
        req = 4'b0100;
        wait_ack(200);
        req    = 4'h0;
        req_rw = 4'h0;
        rd_on  = 1'b0;
        chk("rd_ack", 32'(ack_val), 32'h4);
        chk("rd_rdata", 32'(ack_rd), 32'h3C);
        chk("rd_hdr", 32'(cap[2][15:8]), 32'h81);
        chk("rd_turn_bit", 32'(tf_rises[2]), 8);
        chk("rd_turn_low", 32'(tf_onfall[2]), 1);
        chk("rd_tlow", 32'(tlow[2]), 68);
`else
        req_addr[6:0]  = 7'h01;
        req_wdata[7:0] = 8'h5A;
        req_rw = 4'b0001;
        req = 4'b0001;
        wait_ack(200);
        req    = 4'h0;
        req_rw = 4'h0;
        chk("mo_ack", 32'(ack_val), 32'h1);
        chk("mo_rdata", 32'(ack_rd), 0);
        chk("mo_frame", 32'(cap[0]), 32'h015A);
        chk("mo_sdt", 32'(tlow[0]), 0);
`endif
        repeat (8) step();

        req = 4'b0100;
        n = 0;
        while (rises[2] < 10 && n < 300) begin
            step();
            n++;
        end
        if (rises[2] < 10) chk("bit6_timeout", 0, 1);
        a0 = acks;
        reset_n = 1'b0;
        #1;
        chk("mrst_cs", 32'(spi_cs), 32'hF);
        chk("mrst_sclk", 32'(spi_sclk), 0);
        chk("mrst_sdt", 32'(sdin_t), 0);
        chk("mrst_sdo", 32'(sdin_o), 0);
        chk("mrst_busy", 32'(busy), 0);
        req = 4'h0;
        repeat (5) step();
        chk("mrst_noack", 32'(acks - a0), 0);
        order.delete();
        reset_n = 1'b1;
        step();
        req = 4'b1010;
        wait_fall(1, 50);
        chk("mrst_grant", 32'(q_at(order, 0)), 1);
        req = 4'h0;
        wait_ack(200);
        chk("mrst_ack", 32'(ack_val), 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
